frame_cell: RTL and testbench

//   Single-clock, dual-address frame store for a 640x480 display: one 3-bit

---
 rtl/frame_cell.sv | 83 ++++++++
 tb/tb_frame_cell.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/frame_cell.sv
// Frame store, 640x480 x 3b, one write port and one registered read port.
// Read latency 1 cycle; read_enable=0 holds read_data. No back-pressure: one write + one read per cycle.
// Option FRAME_CELL_WRITE_THROUGH_EN: same-address same-edge read returns the new write_data.
module frame_cell #(
  parameter int FRAME_WIDTH  = 640,
  parameter int FRAME_HEIGHT = 480,
  parameter int DATA_WIDTH   = 3,
  parameter int X_BITS       = 10,
  parameter int Y_BITS       = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [X_BITS-1:0]     write_frame_width,
  input  logic [Y_BITS-1:0]     write_frame_height,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read_enable,
  input  logic [X_BITS-1:0]     read_frame_width,
  input  logic [Y_BITS-1:0]     read_frame_height,
  output logic [DATA_WIDTH-1:0] read_data
);

  localparam int DEPTH     = FRAME_WIDTH * FRAME_HEIGHT;
  localparam int ADDR_BITS = $clog2(DEPTH);

  localparam logic [X_BITS:0]    X_LIM = (X_BITS+1)'(FRAME_WIDTH);
  localparam logic [Y_BITS:0]    Y_LIM = (Y_BITS+1)'(FRAME_HEIGHT);
  localparam logic [ADDR_BITS-1:0] LINE = ADDR_BITS'(FRAME_WIDTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_in_range;
  logic                  rd_in_range;
  logic                  wr_ok;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic [DATA_WIDTH-1:0] ram_q;

  // Out-of-range y can wrap the address product; the range flags gate every use.
  always_comb begin
    wr_in_range = ({1'b0, write_frame_width} < X_LIM) && ({1'b0, write_frame_height} < Y_LIM);
    rd_in_range = ({1'b0, read_frame_width} < X_LIM) && ({1'b0, read_frame_height} < Y_LIM);
    wr_addr     = ADDR_BITS'(write_frame_height) * LINE + ADDR_BITS'(write_frame_width);
    rd_addr     = ADDR_BITS'(read_frame_height) * LINE + ADDR_BITS'(read_frame_width);
    wr_ok       = rst_n && write_enable && wr_in_range;
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_addr] <= write_data;
    end
  end

  // Read-first: the RAM output register samples the pre-write content.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ram_q <= '0;
    end else if (read_enable) begin
      ram_q <= rd_in_range ? mem[rd_addr] : '0;
    end
  end

`ifdef FRAME_CELL_WRITE_THROUGH_EN
  logic                  byp_vld;
  logic [DATA_WIDTH-1:0] byp_dat;

  // Bypass is captured alongside ram_q so it holds with read_enable=0 as well.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byp_vld <= 1'b0;
      byp_dat <= '0;
    end else if (read_enable) begin
      byp_vld <= wr_ok && rd_in_range && (wr_addr == rd_addr);
      byp_dat <= write_data;
    end
  end

  assign read_data = byp_vld ? byp_dat : ram_q;
`else
  assign read_data = ram_q;
`endif

endmodule

// File: tb/tb_frame_cell.sv
// Bench for frame_cell: spec-level memory model checked every cycle plus literal spot checks.
module tb_frame_cell;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] write_frame_width = '0;
  logic [8:0] write_frame_height = '0;
  logic       write_enable = 1'b0;
  logic [2:0] write_data = '0;
  logic       read_enable = 1'b0;
  logic [9:0] read_frame_width = '0;
  logic [8:0] read_frame_height = '0;
  logic [2:0] read_data;

  int checks = 0;
  int fails  = 0;

`ifdef FRAME_CELL_WRITE_THROUGH_EN
  localparam bit WT = 1'b1;
`else
  localparam bit WT = 1'b0;
`endif

  frame_cell dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .write_frame_width  (write_frame_width),
    .write_frame_height (write_frame_height),
    .write_enable       (write_enable),
    .write_data         (write_data),
    .read_enable        (read_enable),
    .read_frame_width   (read_frame_width),
    .read_frame_height  (read_frame_height),
    .read_data          (read_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pixel store as an associative array keyed by linear position.
  bit [2:0] model_mem [int];
  bit [2:0] exp_rd = '0;
  bit       exp_known = 1'b0;

  always @(posedge clk) begin
    int  ra, wa;
    bit  rd_ok, wr_ok;
    rd_ok = (int'(read_frame_width) < 640) && (int'(read_frame_height) < 480);
    wr_ok = (int'(write_frame_width) < 640) && (int'(write_frame_height) < 480) && write_enable;
    ra = int'(read_frame_height) * 640 + int'(read_frame_width);
    wa = int'(write_frame_height) * 640 + int'(write_frame_width);
    if (!rst_n) begin
      exp_rd = '0;
      exp_known = 1'b1;
    end else begin
      if (read_enable) begin
        if (!rd_ok) begin
          exp_rd = '0;
          exp_known = 1'b1;
        end else if (WT && wr_ok && wa == ra) begin
          exp_rd = write_data;
          exp_known = 1'b1;
        end else if (model_mem.exists(ra)) begin
          exp_rd = model_mem[ra];
          exp_known = 1'b1;
        end else begin
          exp_known = 1'b0;
        end
      end
      if (wr_ok) model_mem[wa] = write_data;
    end
  end

  always @(negedge clk) begin
    if (exp_known) chk("model", read_data, exp_rd);
  end

  // One clock with the given enables, returning #1 after the edge.
  task automatic cyc(input bit we, input int wx, input int wy, input int wd,
                     input bit re, input int rx, input int ry);
    write_enable       = we;
    write_frame_width  = 10'(wx);
    write_frame_height = 9'(wy);
    write_data         = 3'(wd);
    read_enable        = re;
    read_frame_width   = 10'(rx);
    read_frame_height  = 9'(ry);
    @(posedge clk);
    #1;
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic rd(input int x, input int y);
    cyc(1'b0, 0, 0, 0, 1'b1, x, y);
  endtask

  task automatic wr(input int x, input int y, input int d);
    cyc(1'b1, x, y, d, 1'b0, 0, 0);
  endtask

  int rows [5] = '{0, 1, 2, 240, 479};

  initial begin
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("reset_state", read_data, 3'd0);
    rst_n = 1'b1;

    // Fill a subset of rows with (y*640+x+1) mod 8, then read them back.
    foreach (rows[r]) for (int x = 0; x < 640; x++) wr(x, rows[r], (rows[r]*640 + x + 1) % 8);
    foreach (rows[r]) for (int x = 0; x < 640; x++) rd(x, rows[r]);
    rd(0, 0);     chk("fill_0_0", read_data, 3'd1);
    rd(7, 0);     chk("fill_7_0", read_data, 3'd0);
    rd(639, 479); chk("fill_639_479", read_data, 3'd0);

    // Latency and hold.
    wr(10, 3, 5);
    chk("hold_after_write", read_data, 3'd0);
    read_enable = 1'b1; read_frame_width = 10'd10; read_frame_height = 9'd3;
    #1;
    chk("latency_before_edge", read_data, 3'd0);
    @(posedge clk); #1;
    read_enable = 1'b0;
    chk("latency_after_edge", read_data, 3'd5);
    cyc(1'b0, 0, 0, 0, 1'b0, 0, 0);
    chk("hold_no_enable", read_data, 3'd5);

    // Same-address collision.
    wr(4, 4, 2);
    cyc(1'b1, 4, 4, 6, 1'b1, 4, 4);
    chk("collision", read_data, WT ? 3'd6 : 3'd2);
    rd(4, 4); chk("after_collision", read_data, 3'd6);

    // Independent ports, different addresses.
    cyc(1'b1, 5, 5, 4, 1'b1, 10, 3);
    chk("indep_read", read_data, 3'd5);
    rd(5, 5); chk("indep_write", read_data, 3'd4);

    // Bounds: (640,0) would alias to (0,1) if not dropped.
    wr(640, 0, 7);
    wr(0, 480, 7);
    rd(0, 1);   chk("oob_x_dropped", read_data, 3'd1);
    rd(0, 0);   chk("oob_y_dropped", read_data, 3'd1);
    rd(700, 10); chk("oob_read_zero", read_data, 3'd0);
    rd(10, 480); chk("oob_read_y_zero", read_data, 3'd0);

    // Reset mid-run preserves memory.
    rd(2, 0); chk("pre_reset_val", read_data, 3'd3);
    rst_n = 1'b0;
    cyc(1'b1, 1, 0, 7, 1'b1, 2, 0);
    rst_n = 1'b1;
    chk("reset_clears_out", read_data, 3'd0);
    rd(1, 0); chk("mem_survives_reset", read_data, 3'd2);

    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
